// File: rtl/chaz_pkg.sv
// Shared definitions for the Hazard3 data-bus bridge and related bus helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: AHB-lite hsize codes, memory-map region codes (adr[17:16]), bridge state encoding.
package chaz_pkg;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Region select taken from adr[17:16] of the SoC memory map
  localparam logic [1:0] REG_RAM  = 2'b00;
  localparam logic [1:0] REG_MMIO = 2'b01;
  localparam logic [1:0] REG_ROM  = 2'b10;
  localparam logic [1:0] REG_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no data phase outstanding
    ST_RD   = 2'd1,  // read data phase: memory returns data this cycle
    ST_WR   = 2'd2,  // write data phase: write issued once the bus is free
    ST_ERR  = 2'd3   // error response pending (only with DBUS_BRIDGE_ERR_EN)
  } state_t;

endpackage

// File: rtl/bus_wmask.sv
// Byte-lane write mask from transfer size and low address bits.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: size (hsize code), addr_lo (address[1:0]), mask (4-bit byte enables, bit n = lane n).
module bus_wmask
  import chaz_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask
);

  always_comb begin
    mask = 4'b1111;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      // Alignment is guaranteed by the core, so only addr[1] picks the half
      HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
  end

endmodule

// File: rtl/hazard3_dbus_bridge.sv
// Hazard3 AHB-lite-style data port to the SoC shared single-port memory bus (RAM/MMIO/ROM).
// Latency: reads issue in the address phase and complete next cycle (1/cycle pipelined);
//          writes issue in the data phase (2 cycles/write). dbg_mem_op stalls new address
//          phases and pending writes; the bus is driven all-zero whenever the CPU is not using it.
// Ports: clk, reset (sync, active high); bus_* core data port; dbg_mem_op debug-master bus
//        ownership; mem_op/mem_adr/mem_di/mem_wren/mem_do shared memory bus.
// Option: DBUS_BRIDGE_ERR_EN adds region decode with error responses for unmapped
//         accesses and ROM writes; without it bus_dph_err_d is tied low.
module hazard3_dbus_bridge
  import chaz_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_aph_req_d,
  output logic              bus_aph_ready_d,
  input  logic [ADDR_W-1:0] bus_haddr_d,
  input  logic [2:0]        bus_hsize_d,
  input  logic              bus_hwrite_d,
  input  logic [DATA_W-1:0] bus_wdata_d,
  output logic [DATA_W-1:0] bus_rdata_d,
  output logic              bus_dph_ready_d,
  output logic              bus_dph_err_d,
  output logic              bus_dph_exokay_d,
  input  logic              dbg_mem_op,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_di,
  output logic [3:0]        mem_wren,
  input  logic [DATA_W-1:0] mem_do
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_size;
  logic              lat_en;
  logic              can_accept;
  logic              acc_err;
  logic [3:0]        wr_mask;

  bus_wmask u_wmask (
    .size    (lat_size),
    .addr_lo (lat_addr[1:0]),
    .mask    (wr_mask)
  );

  // A new address phase is only taken when the data path can absorb it: a
  // pending write owns the next bus slot, and the debug master always wins.
  assign can_accept = bus_aph_req_d & ~dbg_mem_op &
                      ((state == ST_IDLE) || (state == ST_RD));

  always_comb begin
    acc_err = 1'b0;
`ifdef DBUS_BRIDGE_ERR_EN
    acc_err = (bus_haddr_d[17:16] == REG_NONE) |
              (bus_hwrite_d & (bus_haddr_d[17:16] == REG_ROM));
`endif
  end

  always_comb begin
    state_nxt       = state;
    lat_en          = 1'b0;
    bus_aph_ready_d = 1'b0;
    bus_dph_ready_d = 1'b0;
    bus_dph_err_d   = 1'b0;
    bus_rdata_d     = '0;
    mem_op          = 1'b0;
    mem_adr         = '0;
    mem_di          = '0;
    mem_wren        = 4'b0000;

    // Nothing reaches the bus or the core during reset, so a write caught
    // mid-transfer is simply dropped.
    if (!reset) begin
      case (state)
        ST_RD: begin
          // Memory outputs are registered: data for last cycle's select is on
          // mem_do now, even if the debug master took the bus this cycle.
          bus_dph_ready_d = 1'b1;
          bus_rdata_d     = mem_do;
          state_nxt       = ST_IDLE;
        end
        ST_WR: begin
          if (!dbg_mem_op) begin
            mem_op          = 1'b1;
            mem_adr         = lat_addr;
            mem_di          = bus_wdata_d;
            mem_wren        = wr_mask;
            bus_dph_ready_d = 1'b1;
            state_nxt       = ST_IDLE;
          end
        end
`ifdef DBUS_BRIDGE_ERR_EN
        ST_ERR: begin
          bus_dph_ready_d = 1'b1;
          bus_dph_err_d   = 1'b1;
          state_nxt       = ST_IDLE;
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase

      if (can_accept) begin
        bus_aph_ready_d = 1'b1;
        if (acc_err) begin
          state_nxt = ST_ERR;
        end else if (bus_hwrite_d) begin
          // Write data only arrives in the data phase; hold address and size
          lat_en    = 1'b1;
          state_nxt = ST_WR;
        end else begin
          mem_op    = 1'b1;
          mem_adr   = bus_haddr_d;
          state_nxt = ST_RD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      lat_addr <= '0;
      lat_size <= 3'd0;
    end else begin
      state <= state_nxt;
      if (lat_en) begin
        lat_addr <= bus_haddr_d;
        lat_size <= bus_hsize_d;
      end
    end
  end

  assign bus_dph_exokay_d = bus_dph_ready_d & ~bus_dph_err_d;

endmodule

// File: tb/tb_hazard3_dbus_bridge.sv
// Self-checking bench for hazard3_dbus_bridge: directed cycle-level checks plus a
// scoreboard of expected data-phase responses popped whenever bus_dph_ready_d is seen.
// A behavioural registered memory sits on the mem_* bus; a separate reference image
// tracks what the core should read back.
module tb_hazard3_dbus_bridge;
  import chaz_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_aph_req_d = 1'b0;
  logic        bus_aph_ready_d;
  logic [31:0] bus_haddr_d = '0;
  logic [2:0]  bus_hsize_d = '0;
  logic        bus_hwrite_d = 1'b0;
  logic [31:0] bus_wdata_d = '0;
  logic [31:0] bus_rdata_d;
  logic        bus_dph_ready_d;
  logic        bus_dph_err_d;
  logic        bus_dph_exokay_d;
  logic        dbg_mem_op = 1'b0;
  logic        mem_op;
  logic [31:0] mem_adr;
  logic [31:0] mem_di;
  logic [3:0]  mem_wren;
  logic [31:0] mem_do = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard3_dbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_aph_req_d    (bus_aph_req_d),
    .bus_aph_ready_d  (bus_aph_ready_d),
    .bus_haddr_d      (bus_haddr_d),
    .bus_hsize_d      (bus_hsize_d),
    .bus_hwrite_d     (bus_hwrite_d),
    .bus_wdata_d      (bus_wdata_d),
    .bus_rdata_d      (bus_rdata_d),
    .bus_dph_ready_d  (bus_dph_ready_d),
    .bus_dph_err_d    (bus_dph_err_d),
    .bus_dph_exokay_d (bus_dph_exokay_d),
    .dbg_mem_op       (dbg_mem_op),
    .mem_op           (mem_op),
    .mem_adr          (mem_adr),
    .mem_di           (mem_di),
    .mem_wren         (mem_wren),
    .mem_do           (mem_do)
  );

  function automatic logic [31:0] seed(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  // Bus-side memory: registered read, byte-lane writes
  logic [31:0] bmem [0:255];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) bmem[i] <= seed(i);
    end else if (mem_op) begin
      mem_do <= bmem[mem_adr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) bmem[mem_adr[9:2]][8*b +: 8] <= mem_di[8*b +: 8];
    end
  end

  // Reference image of what the core should see
  logic [31:0] rmem [0:255];

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [2:0] sz, input logic [31:0] a);
    if (sz == HSIZE_BYTE) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == HSIZE_HALF) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    exp_t e;
    e.err = 1'b0; e.rd = 1'b1; e.data = rmem[a[9:2]];
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic [3:0] m;
    m = exp_mask(sz, a);
    for (int b = 0; b < 4; b++)
      if (m[b]) rmem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
    e.err = 1'b0; e.rd = 1'b0; e.data = '0;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.rd = 1'b0; e.data = '0;
    sb.push_back(e);
  endtask

  // Data-phase monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus_dph_ready_d) begin
      if (sb.size() == 0) begin
        chk("dph_unexpected", 32'(bus_dph_ready_d), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dph_err", 32'(bus_dph_err_d), 32'(e.err));
        chk("dph_exokay", 32'(bus_dph_exokay_d), 32'(!e.err));
        if (e.rd) chk("rdata", bus_rdata_d, e.data);
      end
    end
  end

  // One cycle of stimulus: inputs change just after the edge, return at the
  // falling edge where outputs are sampled.
  task automatic drive(input logic req, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic dbg, input logic rst);
    @(posedge clk);
    #1;
    reset         = rst;
    bus_aph_req_d = req;
    bus_hwrite_d  = wr;
    bus_hsize_d   = sz;
    bus_haddr_d   = a;
    bus_wdata_d   = wd;
    dbg_mem_op    = dbg;
    @(negedge clk);
  endtask

  int dph_cnt;

  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = seed(i);

    // Reset with a request pending: nothing may be accepted or issued
    drive(1, 0, HSIZE_WORD, 32'h10, 0, 0, 1);
    mem_init = 1'b0;
    chk("rst_aph_ready", 32'(bus_aph_ready_d), 0);
    chk("rst_mem_op", 32'(mem_op), 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_dph_ready", 32'(bus_dph_ready_d), 0);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 1);
    chk("rst_wren", 32'(mem_wren), 0);

    // Word read at 0x10
    drive(1, 0, HSIZE_WORD, 32'h10, 0, 0, 0);
    chk("rd_aph_ready", 32'(bus_aph_ready_d), 1);
    chk("rd_mem_op", 32'(mem_op), 1);
    chk("rd_mem_adr", mem_adr, 32'h10);
    chk("rd_wren", 32'(mem_wren), 0);
    push_rd(32'h10);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("rd_dph_ready", 32'(bus_dph_ready_d), 1);
    chk("rd_rdata", bus_rdata_d, 32'hDEADBEEF);
    chk("idle_mem_adr", mem_adr, 0);
    chk("idle_mem_op", 32'(mem_op), 0);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("idle_dph_ready", 32'(bus_dph_ready_d), 0);

    // Byte write at 0x3
    drive(1, 1, HSIZE_BYTE, 32'h3, 32'hAB000000, 0, 0);
    chk("wb_aph_ready", 32'(bus_aph_ready_d), 1);
    chk("wb_no_op_aph", 32'(mem_op), 0);
    push_wr(HSIZE_BYTE, 32'h3, 32'hAB000000);
    drive(0, 0, HSIZE_WORD, 0, 32'hAB000000, 0, 0);
    chk("wb_mem_op", 32'(mem_op), 1);
    chk("wb_mem_adr", mem_adr, 32'h3);
    chk("wb_wren", 32'(mem_wren), 32'b1000);
    chk("wb_mem_di", mem_di, 32'hAB000000);
    chk("wb_dph_ready", 32'(bus_dph_ready_d), 1);

    // Half write at 0x2
    drive(1, 1, HSIZE_HALF, 32'h2, 32'h12340000, 0, 0);
    push_wr(HSIZE_HALF, 32'h2, 32'h12340000);
    drive(0, 0, HSIZE_WORD, 0, 32'h12340000, 0, 0);
    chk("wh_wren", 32'(mem_wren), 32'b1100);
    chk("wh_mem_adr", mem_adr, 32'h2);

    // Byte write at 0x1
    drive(1, 1, HSIZE_BYTE, 32'h1, 32'h0000CD00, 0, 0);
    push_wr(HSIZE_BYTE, 32'h1, 32'h0000CD00);
    drive(0, 0, HSIZE_WORD, 0, 32'h0000CD00, 0, 0);
    chk("wb1_wren", 32'(mem_wren), 32'b0010);

    // Read back the merged word
    drive(1, 0, HSIZE_WORD, 32'h0, 0, 0, 0);
    push_rd(32'h0);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("merge_dph_ready", 32'(bus_dph_ready_d), 1);

    // Write at 0x4 immediately followed by a read of it
    drive(1, 1, HSIZE_WORD, 32'h4, 32'hCAFEF00D, 0, 0);
    chk("wr4_aph_ready", 32'(bus_aph_ready_d), 1);
    push_wr(HSIZE_WORD, 32'h4, 32'hCAFEF00D);
    drive(1, 0, HSIZE_WORD, 32'h4, 32'hCAFEF00D, 0, 0);
    chk("wr4_hold_aph", 32'(bus_aph_ready_d), 0);
    chk("wr4_wren", 32'(mem_wren), 32'b1111);
    chk("wr4_mem_adr", mem_adr, 32'h4);
    drive(1, 0, HSIZE_WORD, 32'h4, 0, 0, 0);
    chk("rd4_aph_ready", 32'(bus_aph_ready_d), 1);
    chk("rd4_mem_op", 32'(mem_op), 1);
    chk("rd4_wren", 32'(mem_wren), 0);
    push_rd(32'h4);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);

    // Four back-to-back reads finish within five cycles
    dph_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, HSIZE_WORD, 32'h10 + 32'(4 * i), 0, 0, 0);
      chk("b2b_aph_ready", 32'(bus_aph_ready_d), 1);
      chk("b2b_mem_adr", mem_adr, 32'h10 + 32'(4 * i));
      push_rd(32'h10 + 32'(4 * i));
      dph_cnt += int'(bus_dph_ready_d);
    end
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    dph_cnt += int'(bus_dph_ready_d);
    chk("b2b_count", 32'(dph_cnt), 32'd4);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("b2b_done", 32'(bus_dph_ready_d), 0);

    // Debug master holds the bus for three cycles during a write data phase
    drive(1, 1, HSIZE_WORD, 32'h8, 32'h55AA55AA, 0, 0);
    push_wr(HSIZE_WORD, 32'h8, 32'h55AA55AA);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, HSIZE_WORD, 0, 32'h55AA55AA, 1, 0);
      chk("dbgwr_mem_op", 32'(mem_op), 0);
      chk("dbgwr_wren", 32'(mem_wren), 0);
      chk("dbgwr_dph_ready", 32'(bus_dph_ready_d), 0);
    end
    drive(0, 0, HSIZE_WORD, 0, 32'h55AA55AA, 0, 0);
    chk("dbgwr_issue_op", 32'(mem_op), 1);
    chk("dbgwr_issue_adr", mem_adr, 32'h8);
    chk("dbgwr_issue_wren", 32'(mem_wren), 32'b1111);
    chk("dbgwr_issue_dph", 32'(bus_dph_ready_d), 1);

    // Debug takes the bus during a read data phase; launched data still returns
    drive(1, 0, HSIZE_WORD, 32'h8, 0, 0, 0);
    push_rd(32'h8);
    drive(1, 0, HSIZE_WORD, 32'hC, 0, 1, 0);
    chk("dbgrd_dph_ready", 32'(bus_dph_ready_d), 1);
    chk("dbgrd_aph_held", 32'(bus_aph_ready_d), 0);
    chk("dbgrd_mem_op", 32'(mem_op), 0);
    drive(1, 0, HSIZE_WORD, 32'hC, 0, 0, 0);
    chk("dbgrd_aph_release", 32'(bus_aph_ready_d), 1);
    push_rd(32'hC);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);

    // Reset during the write data phase drops the write
    drive(1, 1, HSIZE_WORD, 32'hC, 32'hFFFFFFFF, 0, 0);
    chk("rstwr_aph_ready", 32'(bus_aph_ready_d), 1);
    drive(0, 0, HSIZE_WORD, 0, 32'hFFFFFFFF, 0, 1);
    chk("rstwr_mem_op", 32'(mem_op), 0);
    chk("rstwr_wren", 32'(mem_wren), 0);
    chk("rstwr_dph_ready", 32'(bus_dph_ready_d), 0);
    drive(1, 0, HSIZE_WORD, 32'hC, 0, 0, 0);
    chk("rstwr_idle_aph", 32'(bus_aph_ready_d), 1);
    chk("rstwr_idle_wren", 32'(mem_wren), 0);
    push_rd(32'hC);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);

    // Access to the unmapped region
`ifdef DBUS_BRIDGE_ERR_EN
    drive(1, 0, HSIZE_WORD, 32'h00030000, 0, 0, 0);
    chk("err_aph_ready", 32'(bus_aph_ready_d), 1);
    chk("err_mem_op", 32'(mem_op), 0);
    push_err();
    drive(1, 0, HSIZE_WORD, 32'h10, 0, 0, 0);
    chk("err_dph_ready", 32'(bus_dph_ready_d), 1);
    chk("err_dph_err", 32'(bus_dph_err_d), 1);
    chk("err_exokay", 32'(bus_dph_exokay_d), 0);
    chk("err_aph_held", 32'(bus_aph_ready_d), 0);
    drive(1, 1, HSIZE_WORD, 32'h00020000, 32'h11111111, 0, 0);
    chk("romwr_aph_ready", 32'(bus_aph_ready_d), 1);
    push_err();
    drive(0, 0, HSIZE_WORD, 0, 32'h11111111, 0, 0);
    chk("romwr_mem_op", 32'(mem_op), 0);
    chk("romwr_dph_err", 32'(bus_dph_err_d), 1);
`else
    drive(1, 0, HSIZE_WORD, 32'h00030000, 0, 0, 0);
    chk("unmap_mem_op", 32'(mem_op), 1);
    chk("unmap_mem_adr", mem_adr, 32'h00030000);
    push_rd(32'h00030000);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("unmap_dph_ready", 32'(bus_dph_ready_d), 1);
    chk("unmap_dph_err", 32'(bus_dph_err_d), 0);
    chk("unmap_exokay", 32'(bus_dph_exokay_d), 1);
`endif

    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    drive(0, 0, HSIZE_WORD, 0, 0, 0, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
